// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor constants: instruction format codes, J-type sub-codes and
// the fetch FSM encodings used by the fetch unit and the control unit.
package instr_fetch_unit_pkg;

    typedef logic [15:0] instr_t;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;
    localparam logic [1:0] FMT_M = 2'b11;

    localparam logic [2:0] JC_JMP  = 3'b000;
    localparam logic [2:0] JC_JZ   = 3'b001;
    localparam logic [2:0] JC_HALT = 3'b111;

    localparam logic [1:0] S_ADDR  = 2'b00;
    localparam logic [1:0] S_READY = 2'b01;
    localparam logic [1:0] S_EXEC  = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    function automatic logic is_halt(input instr_t instr);
        return (instr[1:0] == FMT_J) && (instr[4:2] == JC_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Combinational next-PC selection: sequential increment, JMP, conditional JZ,
// and HALT (PC holds).
module pc_next_logic
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  instr_t              instruction_i,
    input  logic                alu_zero_i,
    output logic [PC_WIDTH-1:0] next_pc_o
);

    logic [PC_WIDTH+7:0] target_ext;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                unused_bits;

    // The 8-bit jump field is zero-extended or truncated to fit any PC width.
    assign target_ext  = {{PC_WIDTH{1'b0}}, instruction_i[12:5]};
    assign target      = target_ext[PC_WIDTH-1:0];
    assign pc_inc      = pc_i + PC_WIDTH'(1);
    assign unused_bits = ^{instruction_i[15:13], target_ext[PC_WIDTH+7:PC_WIDTH]};

    always_comb begin
        next_pc_o = pc_inc;
        if (instruction_i[1:0] == FMT_J) begin
            case (instruction_i[4:2])
                JC_JMP:  next_pc_o = target;
                JC_JZ:   if (alu_zero_i) next_pc_o = target;
                JC_HALT: next_pc_o = pc_i;
                default: next_pc_o = pc_inc;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the synchronous ROM address, latches the
// fetched word on request from the control unit and advances the PC.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                en_i,
    input  logic                done2,
    input  logic                alu_zero,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_rdata,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instruction,
    output logic                fetch_ready,
    output logic                halted
);

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    instr_t              instr_q, instr_d;
    logic                pending_q, pending_d;
    logic [PC_WIDTH-1:0] next_pc;

    pc_next_logic #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc_i          (pc_q),
        .instruction_i (instr_q),
        .alu_zero_i    (alu_zero),
        .next_pc_o     (next_pc)
    );

    // With run low every _d equals its _q, so all state and strobes freeze.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pending_d = pending_q;
        if (run) begin
            case (state_q)
                S_ADDR: begin
                    state_d = S_READY;
                    if (en_i) pending_d = 1'b1;
                end
                S_READY: begin
                    if (en_i || pending_q) begin
                        instr_d   = mem_rdata;
                        pending_d = 1'b0;
                        state_d   = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (done2) begin
                        pc_d    = next_pc;
                        state_d = is_halt(instr_q) ? S_HALT : S_ADDR;
                    end
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_ADDR;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pending_q <= pending_d;
        end
    end

    assign pc          = pc_q;
    assign mem_addr    = pc_q;
    assign instruction = instr_q;
    assign fetch_ready = (state_q == S_READY);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a synchronous ROM model and a
// scoreboard of expected fetches.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, run, en_i, done2, alu_zero;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_rdata, instruction;
    logic        fetch_ready, halted;

    logic [15:0] rom [0:255];

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .en_i        (en_i),
        .done2       (done2),
        .alu_zero    (alu_zero),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pc          (pc),
        .instruction (instruction),
        .fetch_ready (fetch_ready),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= rom[mem_addr];

    // Independent reference for the next-PC rule.
    function automatic logic [7:0] model_next(input logic [7:0] p, input logic [15:0] ins, input logic z);
        if (ins[1:0] != 2'b10) return p + 8'd1;
        case (ins[4:2])
            3'b000:  return ins[12:5];
            3'b001:  return z ? ins[12:5] : p + 8'd1;
            3'b111:  return p;
            default: return p + 8'd1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b1; en_i = 1'b0; done2 = 1'b0; alu_zero = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fetch_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            en_i = 1'b1;
            tick();
            en_i = 1'b0;
        end
    endtask

    task automatic retire();
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; en_i = 1'b1; done2 = 1'b1; alu_zero = 1'b0;
        tick();
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL reset_pc: got %h expected 00", pc); end
        total++; if (instruction !== 16'h0000) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 0000", instruction); end
        total++; if (fetch_ready !== 1'b0 || halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: got ready=%b halted=%b expected 0 0", fetch_ready, halted); end
        reset = 1'b0; run = 1'b1; en_i = 1'b0; done2 = 1'b0;
        tick();
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_addr: got %b expected 1", fetch_ready); end
    endtask

    task automatic test_basic();
        exp_t e, got;
        rom[0] = 16'h2005;
        do_reset();
        tick();
        e.pc = 8'h00; e.instr = rom[0]; sbq.push_back(e);
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready: got %b expected 1", fetch_ready); end
        en_i = 1'b1; tick(); en_i = 1'b0;
        got = sbq.pop_front();
        total++; if (instruction !== got.instr || pc !== got.pc) begin bad++; $display("[TB] FAIL basic_latch: got instr=%h pc=%h expected instr=%h pc=%h", instruction, pc, got.instr, got.pc); end
        retire();
        total++; if (pc !== 8'h01 || mem_addr !== 8'h01) begin bad++; $display("[TB] FAIL basic_advance: got pc=%h addr=%h expected 01", pc, mem_addr); end
    endtask

    task automatic test_wrap();
        bit ok;
        rom[8'h00] = 16'h1FE2;
        rom[8'hFF] = 16'h0000;
        do_reset();
        fetch(ok);
        retire();
        total++; if (!ok || pc !== 8'hFF) begin bad++; $display("[TB] FAIL wrap_setup: got ok=%b pc=%h expected 1 ff", ok, pc); end
        fetch(ok);
        retire();
        total++; if (!ok || pc !== 8'h00 || fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL wrap_pc: got ok=%b pc=%h ready=%b expected 1 00 0", ok, pc, fetch_ready); end
        tick();
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ready: got %b expected 1", fetch_ready); end
    endtask

    task automatic test_jumps();
        bit         ok;
        exp_t       e, got;
        logic [7:0] pc_e;
        logic       zv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rom[8'h00] = 16'h0802;
        rom[8'h40] = 16'h00A2;
        rom[8'h05] = 16'h0406;
        rom[8'h06] = 16'h0606;
        rom[8'h30] = 16'h020A;
        do_reset();
        pc_e = 8'h00;
        for (int i = 0; i < 5; i++) begin
            e.pc = pc_e; e.instr = rom[pc_e]; sbq.push_back(e);
            fetch(ok);
            got = sbq.pop_front();
            total++;
            if (!ok) begin
                bad++; $display("[TB] FAIL jump_timeout step %0d: fetch_ready never rose", i);
                break;
            end
            if (instruction !== got.instr || pc !== got.pc) begin bad++; $display("[TB] FAIL jump_fetch step %0d: got instr=%h pc=%h expected instr=%h pc=%h", i, instruction, pc, got.instr, got.pc); end
            alu_zero = zv[i];
            retire();
            alu_zero = 1'b0;
            pc_e = model_next(got.pc, got.instr, zv[i]);
            total++; if (pc !== pc_e) begin bad++; $display("[TB] FAIL jump_next step %0d: got pc=%h expected %h", i, pc, pc_e); end
        end
    endtask

    task automatic test_halt();
        bit ok;
        rom[8'h00] = 16'h0062;
        rom[8'h03] = 16'h001E;
        do_reset();
        fetch(ok); retire();
        fetch(ok);
        total++; if (!ok || pc !== 8'h03 || halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_setup: got ok=%b pc=%h halted=%b expected 1 03 0", ok, pc, halted); end
        retire();
        total++; if (halted !== 1'b1 || pc !== 8'h03) begin bad++; $display("[TB] FAIL halt_enter: got halted=%b pc=%h expected 1 03", halted, pc); end
        for (int i = 0; i < 10; i++) begin
            done2 = 1'b1; en_i = 1'b1; tick();
            done2 = 1'b0; en_i = 1'b0; tick();
            total++; if (pc !== 8'h03 || halted !== 1'b1 || fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL halt_hold %0d: got pc=%h halted=%b ready=%b expected 03 1 0", i, pc, halted, fetch_ready); end
        end
        do_reset();
        total++; if (pc !== 8'h00 || halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_reset: got pc=%h halted=%b expected 00 0", pc, halted); end
    endtask

    task automatic test_pending_and_run();
        rom[8'h00] = 16'h0001;
        do_reset();
        en_i = 1'b1; tick(); en_i = 1'b0;
        total++; if (fetch_ready !== 1'b1 || instruction !== 16'h0000) begin bad++; $display("[TB] FAIL pending_wait: got ready=%b instr=%h expected 1 0000", fetch_ready, instruction); end
        tick();
        total++; if (instruction !== 16'h0001 || fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL pending_latch: got instr=%h ready=%b expected 0001 0", instruction, fetch_ready); end
        rom[8'h00] = 16'hBEEF;
        tick();
        en_i = 1'b1; tick(); en_i = 1'b0;
        total++; if (instruction !== 16'h0001) begin bad++; $display("[TB] FAIL exec_en_ignored: got %h expected 0001", instruction); end
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            done2 = (i % 2 == 0); tick();
        end
        done2 = 1'b0; run = 1'b1;
        total++; if (pc !== 8'h00 || instruction !== 16'h0001) begin bad++; $display("[TB] FAIL run_freeze: got pc=%h instr=%h expected 00 0001", pc, instruction); end
        retire();
        total++; if (pc !== 8'h01) begin bad++; $display("[TB] FAIL run_resume: got pc=%h expected 01", pc); end
    endtask

    task automatic test_reset_in_ready();
        rom[8'h00] = 16'h1234;
        do_reset();
        tick();
        en_i = 1'b1; reset = 1'b1; tick();
        total++; if (instruction !== 16'h0000 || fetch_ready !== 1'b0 || pc !== 8'h00) begin bad++; $display("[TB] FAIL ready_reset: got instr=%h ready=%b pc=%h expected 0000 0 00", instruction, fetch_ready, pc); end
        en_i = 1'b0; reset = 1'b0; tick();
        total++; if (fetch_ready !== 1'b1 || instruction !== 16'h0000) begin bad++; $display("[TB] FAIL ready_no_latch: got ready=%b instr=%h expected 1 0000", fetch_ready, instruction); end
        done2 = 1'b1; tick(); done2 = 1'b0;
        total++; if (pc !== 8'h00 || fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL done2_outside_exec: got pc=%h ready=%b expected 00 1", pc, fetch_ready); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        reset = 1'b1; run = 1'b1; en_i = 1'b0; done2 = 1'b0; alu_zero = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_wrap();
        test_jumps();
        test_halt();
        test_pending_and_run();
        test_reset_in_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
